muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, consuming operands and funct3 from the ID/EX pipeline register alongside the main ALU. It takes a multi-cycle M-extension operation and raises a stall for IF/ID/ID-EX until the result is ready. In its single done cycle it presents an XLEN-bit result for the EX/MEM register.

## Interface
- XLEN, 32: operand/result width; iteration count = XLEN
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- flush  in  1  synchronous abort (branch/jump flush of EX); forces IDLE
- start  in  1  EX instruction is an M-op (MulDivE); held high by stall until done
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand (forwarded SrcAE)
- b  in  XLEN  rs2 operand (forwarded SrcBE)
- stall  out  1  hold IF/ID/ID-EX, bubble EX/MEM
- done  out  1  result valid this cycle (one-cycle pulse)
- result  out  XLEN  selected result; 0 when done=0

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 and flush=0 → capture a, b, funct3; compute sign flags and magnitudes; go to CALC with count=0. start is sampled only in IDLE.
- Fast path from IDLE to DONE, skipping CALC:
  - divide by zero: quotient = all ones; remainder = a
  - signed overflow DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0
- CALC, multiply: shift-add on magnitudes, one bit per cycle, into a 2·XLEN product.
- CALC, divide: restoring divide on magnitudes, one quotient bit per cycle.
- CALC ends after XLEN iterations (count = XLEN-1) → DONE.
- DONE: apply sign correction and present the result:
  - MUL: low half of product
  - MULH/MULHSU/MULHU: high half of product
  - DIV/DIVU: quotient
  - REM/REMU: remainder
  - Product negated when operand signs differ, using signed interpretation per op: MULHSU treats b as unsigned; MULHU and DIVU/REMU are fully unsigned.
  - Quotient negative when signs differ; remainder takes the sign of a.
- DONE always returns to IDLE next cycle.
- Reset values: state=IDLE, count=0, internal accumulators 0, stall=0, done=0, result=0.

## Timing
- stall = (IDLE & start & ~flush) | CALC. Combinational, so the instruction is held in the same cycle it arrives.
- Normal latency: start seen in cycle 0 → CALC cycles 1..XLEN → done=1 in cycle XLEN+1. That is 33 cycles for XLEN=32.
- Fast path: done=1 in cycle 1.
- In DONE: stall=0, so the pipeline advances exactly one instruction. start may still be high; it is ignored.
- Back-to-back M-ops: the next op arrives in EX during the IDLE cycle after DONE and starts normally. There is no 1-cycle overlap.
- flush in any state → IDLE next cycle; no done pulse; stall drops the same cycle flush is high.
- reset mid-CALC → IDLE next edge. Operands captured earlier are discarded.
- a/b/funct3 changes after capture have no effect.
- Width rules:
  - count is $clog2(XLEN) bits
  - product register is 2·XLEN bits
  - remainder register is XLEN+1 bits for the subtract-and-test
  - all negation is two's complement mod 2^XLEN (2^(2·XLEN) for the product)

## Structure
- Shared package riscv_pkg holds:
  - muldiv_op_t enum for funct3 encodings
  - muldiv_state_t enum (IDLE, CALC, DONE)
  - XLEN default constant
- Single module; no sub-module required.
- Sign pre/post-processing (abs, conditional negate) lives as functions in riscv_pkg.
- The hazard unit ORs stall into StallF/StallD/FlushE.

## Test plan
- MUL a=7, b=-3 (0xFFFFFFFD) → stall high cycles 0..32; done at cycle 33; result=0xFFFFFFEB.
- MULH/MULHSU/MULHU with a=b=0x80000000 → 0x40000000 / 0xC0000000 / 0x40000000.
- DIV a=-7, b=2 → 0xFFFFFFFD; REM a=-7, b=2 → 0xFFFFFFFF; DIVU a=7, b=2 → 3; REMU a=7, b=2 → 1.
- DIVU a=5, b=0 → done at cycle 1, result=0xFFFFFFFF; REM a=5, b=0 → 5; DIV 0x80000000/-1 → done at cycle 1, result=0x80000000.
- flush asserted at CALC iteration 10 → IDLE next cycle, stall=0, no done pulse. Reset mid-CALC behaves the same and all outputs read 0.
- Back-to-back: DIVU 100/7 immediately followed by MUL 6×7 → results 14, then 42. Exactly one done pulse each; no start re-trigger in DONE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 encodings, muldiv FSM states,
// and the sign pre/post-processing helpers used by the iterative multiply/divide unit.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // Magnitude of x when it is interpreted as signed, otherwise x unchanged.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
        return (is_signed && x[XLEN-1]) ? ('0 - x) : x;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x,
                                                 input logic            neg);
        return neg ? ('0 - x) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] x,
                                                        input logic              neg);
        return neg ? ('0 - x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, with a one-cycle done pulse.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t     r_state;
    muldiv_state_t     w_state_next;
    muldiv_op_t        r_op;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mcand;      // multiplicand or divisor magnitude
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic              r_neg_prod;
    logic              r_neg_quo;
    logic              r_neg_rem;

    muldiv_op_t        w_op;
    logic              w_is_div;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_fast;
    logic              w_accept;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN+1:0]   w_div_shift;
    logic [XLEN+1:0]   w_div_diff;
    logic              w_div_ok;

    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_res_sel;

    // Operand decode, evaluated on the live ID/EX inputs during the capture cycle.
    assign w_op       = muldiv_op_t'(funct3);
    assign w_is_div   = funct3[2];
    assign w_sign_a   = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_sign_b   = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                        (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_neg_a    = w_sign_a && a[XLEN-1];
    assign w_neg_b    = w_sign_b && b[XLEN-1];
    assign w_abs_a    = abs_val(a, w_sign_a);
    assign w_abs_b    = abs_val(b, w_sign_b);
    assign w_div_zero = w_is_div && (b == '0);
    assign w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_fast     = w_div_zero || w_overflow;
    assign w_accept   = (r_state == IDLE) && start && !flush;

    // One shift-add step: conditionally add into the high half, then shift right.
    assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    // One restoring step: bring in the next dividend bit, keep the difference if non-negative.
    assign w_div_shift = {r_rem, r_quo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_mcand};
    assign w_div_ok    = !w_div_diff[XLEN+1];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_fast ? DONE : CALC;
            CALC:    if (r_count == CW'(XLEN-1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    // NOTE: state registers use non-blocking assignment so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= OP_MUL;
            r_count    <= '0;
            r_prod     <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_neg_prod <= 1'b0;
            r_neg_quo  <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_op;
                        r_count    <= '0;
                        r_mcand    <= w_is_div ? w_abs_b : w_abs_a;
                        r_prod     <= {{XLEN{1'b0}}, w_abs_b};
                        r_neg_prod <= w_neg_a ^ w_neg_b;
                        // Fast-path results are preloaded so DONE needs no extra mux.
                        if (w_div_zero) begin
                            r_quo     <= '1;
                            r_rem     <= {1'b0, a};
                            r_neg_quo <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else if (w_overflow) begin
                            r_quo     <= {1'b1, {(XLEN-1){1'b0}}};
                            r_rem     <= '0;
                            r_neg_quo <= 1'b0;
                            r_neg_rem <= 1'b0;
                        end else begin
                            r_quo     <= w_abs_a;
                            r_rem     <= '0;
                            r_neg_quo <= w_neg_a ^ w_neg_b;
                            r_neg_rem <= w_neg_a;
                        end
                    end
                end
                CALC: begin
                    r_count <= r_count + CW'(1);
                    if (r_op[2]) begin
                        r_rem <= w_div_ok ? w_div_diff[XLEN:0] : w_div_shift[XLEN:0];
                        r_quo <= {r_quo[XLEN-2:0], w_div_ok};
                    end else begin
                        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_prod_fix = cond_neg_wide(r_prod, r_neg_prod);
    assign w_quo_fix  = cond_neg(r_quo, r_neg_quo);
    assign w_rem_fix  = cond_neg(r_rem[XLEN-1:0], r_neg_rem);

    always_comb begin
        w_res_sel = '0;
        case (r_op)
            OP_MUL:                        w_res_sel = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_res_sel = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_res_sel = w_quo_fix;
            default:                       w_res_sel = w_rem_fix;
        endcase
    end

    // A flush kills the EX instruction immediately, so it also masks stall and done.
    assign stall  = !flush && (((r_state == IDLE) && start) || (r_state == CALC));
    assign done   = !flush && (r_state == DONE);
    assign result = done ? w_res_sel : '0;

endmodule
